ps2_mouse_packet: RTL and testbench
===================================

# ps2_mouse_packet

Upstream stage of the mouse datapath: enables streaming on a PS/2 mouse, then assembles its 3-byte movement packets into a 9-bit two's-complement X/Y displacement plus button state with a one-cycle done tick. Consumes byte ticks from the PS/2 receiver and drives the PS/2 transmitter. Feeds the LED position counter and any later cursor logic.

## Interface

Parameters:
- TIMEOUT, default 1_000_000, idle clk cycles allowed between bytes of one packet, or between tx completion and ack (20 ms at 50 MHz).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- reset  input  1  asynchronous, active-high.
- rx_data  input  8  byte from PS/2 receiver, valid when rx_done_tick=1.
- rx_done_tick  input  1  one-cycle pulse per received byte.
- tx_done_tick  input  1  one-cycle pulse when transmitter finishes a byte.
- wr_ps2  output  1  one-cycle request to transmit tx_data.
- tx_data  output  8  constant 8'hF4 (enable data reporting).
- init_done  output  1  high once ack 8'hFA received; stays high until reset.
- xm  output  9  X displacement, two's complement.
- ym  output  9  Y displacement, two's complement.
- btnm  output  3  {middle, right, left}.
- m_done_tick  output  1  one-cycle pulse, new packet on xm/ym/btnm.

## Operation

- States: INIT_SEND, INIT_WAIT_TX, INIT_WAIT_ACK, PKT1, PKT2, PKT3, DONE.
- INIT_SEND: wr_ps2=1 for exactly one cycle → INIT_WAIT_TX.
- INIT_WAIT_TX: wait tx_done_tick → INIT_WAIT_ACK, timeout counter cleared. rx_done_tick ignored here and in INIT_SEND.
- INIT_WAIT_ACK: byte 8'hFA → init_done=1, PKT1. Any other byte, or TIMEOUT cycles with no byte → INIT_SEND (retry, unlimited).
- PKT1: accept byte only if bit3=1; store as b1 → PKT2. Byte with bit3=0 dropped, stay in PKT1 (resync). No timeout in PKT1.
- PKT2: store b2 → PKT3. PKT3: store b3 → DONE.
- PKT2/PKT3: counter cleared on entry and on each accepted byte; reaching TIMEOUT-1 with no byte → PKT1, partial packet discarded, no tick.
- DONE: one cycle; register outputs, m_done_tick=1 → PKT1. A byte arriving during DONE is lost; devices space bytes far apart, not a supported case.
- Byte 1 layout: [0]L [1]R [2]M [3]1 [4]Xsign [5]Ysign [6]Xovf [7]Yovf.
- btnm = b1[2:0]; xm = {b1[4], b2}; ym = {b1[5], b3}.
- Overflow saturation: Xovf=1 → xm = Xsign ? 9'h100 (−256) : 9'h0FF (+255); same for Y with Yovf/Ysign.
- xm/ym/btnm hold last packet values between ticks.
- Timeout counter width ceil(log2(TIMEOUT)); never wraps (saturates/resets per state).

## Timing

- Reset values: wr_ps2=0, init_done=0, xm=0, ym=0, btnm=0, m_done_tick=0; state INIT_SEND; tx_data always 8'hF4.
- First rising edge after reset deassert: wr_ps2 goes high for that cycle.
- Byte-3 rx_done_tick at cycle N → m_done_tick=1 and new xm/ym/btnm visible at cycle N+1; m_done_tick low at N+2.
- Outputs update in the same cycle as m_done_tick; consumer samples when tick high.
- FA received at cycle N → init_done=1 from N+1.
- Reset mid-operation (any state): immediate return to reset values; init sequence restarts, previous init_done lost.

## Test plan

- Reset release → wr_ps2 pulse one cycle; tx_done_tick then rx FA → init_done=1, no m_done_tick.
- Init: rx 8'hFE instead of FA → second wr_ps2 pulse; then FA → init_done=1. Also no byte for TIMEOUT cycles after tx_done → wr_ps2 again.
- Packet 8'h09, 8'h05, 8'hFD → m_done_tick one cycle, btnm=3'b001, xm=9'h005, ym=9'h0FD (+253); packet 8'h38, 8'hFB, 8'h02 → xm=9'h1FB (−5), ym=9'h102, btnm=0.
- Sync: bytes 8'h05 (bit3=0) then 8'h08, 8'h01, 8'h01 → exactly one tick, xm=1, ym=1; first byte discarded.
- Timeout: 8'h08, 8'h10, then silence > TIMEOUT → no tick; next full packet 8'h0A, 8'h00, 8'h00 → tick, btnm=3'b010.
- Overflow: 8'h58 (Xovf, Xsign), 8'h00, 8'h00 → xm=9'h100; reset asserted mid-packet after byte 2 → all outputs 0, wr_ps2 pulse after release.

Source files
------------

// File: rtl/ps2_mouse_packet.sv
// PS/2 mouse front end: sends the enable-reporting command, waits for the ack,
// then assembles 3-byte movement packets into 9-bit X/Y displacement plus buttons.
module ps2_mouse_packet #(
    parameter int TIMEOUT = 1_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] rx_data,
    input  logic       rx_done_tick,
    input  logic       tx_done_tick,
    output logic       wr_ps2,
    output logic [7:0] tx_data,
    output logic       init_done,
    output logic [8:0] xm,
    output logic [8:0] ym,
    output logic [2:0] btnm,
    output logic       m_done_tick
);

    typedef enum logic [2:0] {
        INIT_SEND     = 3'd0,
        INIT_WAIT_TX  = 3'd1,
        INIT_WAIT_ACK = 3'd2,
        PKT1          = 3'd3,
        PKT2          = 3'd4,
        PKT3          = 3'd5,
        DONE          = 3'd6
    } state_t;

    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(TIMEOUT - 1);

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    // Header byte without its always-one sync bit: {Yovf, Xovf, Ysign, Xsign, M, R, L}
    logic [6:0]    hdr_r;
    logic [7:0]    b2_r;

    // Saturate to the extreme representable value when the device flags overflow.
    function automatic logic [8:0] axis_value(input logic sign, input logic ovf,
                                              input logic [7:0] mag);
        logic [8:0] v;
        if (ovf) begin
            v = sign ? 9'h100 : 9'h0FF;
        end else begin
            v = {sign, mag};
        end
        return v;
    endfunction

    assign tx_data = 8'hF4;

    // Init handshake and packet assembly FSM with registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= INIT_SEND;
            cnt_r       <= '0;
            hdr_r       <= 7'd0;
            b2_r        <= 8'd0;
            wr_ps2      <= 1'b0;
            init_done   <= 1'b0;
            xm          <= 9'd0;
            ym          <= 9'd0;
            btnm        <= 3'd0;
            m_done_tick <= 1'b0;
        end else begin
            wr_ps2      <= 1'b0;
            m_done_tick <= 1'b0;
            case (state_r)
                INIT_SEND: begin
                    wr_ps2  <= 1'b1;
                    state_r <= INIT_WAIT_TX;
                end
                INIT_WAIT_TX: begin
                    if (tx_done_tick) begin
                        cnt_r   <= '0;
                        state_r <= INIT_WAIT_ACK;
                    end else begin
                        state_r <= INIT_WAIT_TX;
                    end
                end
                INIT_WAIT_ACK: begin
                    if (rx_done_tick) begin
                        if (rx_data == 8'hFA) begin
                            init_done <= 1'b1;
                            state_r   <= PKT1;
                        end else begin
                            state_r   <= INIT_SEND;
                        end
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= INIT_SEND;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                PKT1: begin
                    // Bit 3 is always set in a header byte; anything else means we are out of step.
                    if (rx_done_tick && rx_data[3]) begin
                        hdr_r   <= {rx_data[7:4], rx_data[2:0]};
                        cnt_r   <= '0;
                        state_r <= PKT2;
                    end else begin
                        state_r <= PKT1;
                    end
                end
                PKT2: begin
                    if (rx_done_tick) begin
                        b2_r    <= rx_data;
                        cnt_r   <= '0;
                        state_r <= PKT3;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= PKT1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                PKT3: begin
                    if (rx_done_tick) begin
                        xm          <= axis_value(hdr_r[3], hdr_r[5], b2_r);
                        ym          <= axis_value(hdr_r[4], hdr_r[6], rx_data);
                        btnm        <= hdr_r[2:0];
                        m_done_tick <= 1'b1;
                        state_r     <= DONE;
                    end else if (cnt_r == CNT_MAX) begin
                        state_r <= PKT1;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                DONE: begin
                    state_r <= PKT1;
                end
                default: begin
                    state_r <= INIT_SEND;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ps2_mouse_packet.sv
// Randomized self-checking bench for ps2_mouse_packet against an arithmetic
// packet-decoding model.
module tb_ps2_mouse_packet;
    localparam int TO = 20;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] rx_data = 8'd0;
    logic       rx_done_tick = 1'b0;
    logic       tx_done_tick = 1'b0;
    logic       wr_ps2;
    logic [7:0] tx_data;
    logic       init_done;
    logic [8:0] xm;
    logic [8:0] ym;
    logic [2:0] btnm;
    logic       m_done_tick;

    int total = 0;
    int passed = 0;
    int tick_count = 0;
    int wr_count = 0;

    ps2_mouse_packet #(.TIMEOUT(TO)) dut (
        .clk(clk), .reset(reset), .rx_data(rx_data), .rx_done_tick(rx_done_tick),
        .tx_done_tick(tx_done_tick), .wr_ps2(wr_ps2), .tx_data(tx_data),
        .init_done(init_done), .xm(xm), .ym(ym), .btnm(btnm), .m_done_tick(m_done_tick)
    );

    always #5 clk = ~clk;

    // Event counters for pulses observed on the DUT outputs.
    always @(posedge clk) begin
        if (m_done_tick) tick_count <= tick_count + 1;
        if (wr_ps2) wr_count <= wr_count + 1;
    end

    // Expected {btnm, xm, ym}: signed displacement as an integer, clamped on overflow.
    function automatic logic [20:0] model(input logic [7:0] h, input logic [7:0] bx,
                                          input logic [7:0] by);
        int x;
        int y;
        x = h[4] ? int'(bx) - 256 : int'(bx);
        y = h[5] ? int'(by) - 256 : int'(by);
        if (h[6]) x = h[4] ? -256 : 255;
        if (h[7]) y = h[5] ? -256 : 255;
        return {h[2:0], x[8:0], y[8:0]};
    endfunction

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data = b;
        rx_done_tick = 1'b1;
        step(1);
        rx_done_tick = 1'b0;
        rx_data = 8'($urandom);
    endtask

    task automatic pulse_tx();
        tx_done_tick = 1'b1;
        step(1);
        tx_done_tick = 1'b0;
    endtask

    task automatic bring_up();
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_tx();
        step(2);
        send_byte(8'hFA);
        step(1);
    endtask

    task automatic test_reset();
        int t0;
        reset = 1'b1;
        step(2);
        total++;
        if ({wr_ps2, init_done, xm, ym, btnm, m_done_tick} !== 24'd0)
            $display("FAIL reset_outputs: got %h expected 0", {wr_ps2, init_done, xm, ym, btnm, m_done_tick});
        else passed++;
        total++;
        if (tx_data !== 8'hF4) $display("FAIL tx_data: got %h expected f4", tx_data);
        else passed++;
        reset = 1'b0;
        step(1);
        total++;
        if (wr_ps2 !== 1'b1) $display("FAIL first_wr: got %b expected 1", wr_ps2);
        else passed++;
        step(1);
        total++;
        if (wr_ps2 !== 1'b0) $display("FAIL wr_one_cycle: got %b expected 0", wr_ps2);
        else passed++;
        step(3);
        pulse_tx();
        step(2);
        total++;
        if (init_done !== 1'b0) $display("FAIL init_before_ack: got %b expected 0", init_done);
        else passed++;
        t0 = tick_count;
        send_byte(8'hFA);
        total++;
        if (init_done !== 1'b1) $display("FAIL init_after_ack: got %b expected 1", init_done);
        else passed++;
        step(3);
        total++;
        if (tick_count !== t0) $display("FAIL init_no_tick: got %0d expected %0d", tick_count, t0);
        else passed++;
    endtask

    task automatic test_init_retry();
        int w0;
        bit seen;
        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_tx();
        step(1);
        send_byte(8'hFE);
        seen = 1'b0;
        for (int i = 0; i < 5 && !seen; i++) begin
            step(1);
            if (wr_ps2) seen = 1'b1;
        end
        total++;
        if (!seen || init_done !== 1'b0)
            $display("FAIL nak_retry: got wr=%b init=%b expected wr=1 init=0", seen, init_done);
        else passed++;
        step(1);
        pulse_tx();
        step(1);
        send_byte(8'hFA);
        total++;
        if (init_done !== 1'b1) $display("FAIL retry_ack: got %b expected 1", init_done);
        else passed++;

        reset = 1'b1;
        step(2);
        reset = 1'b0;
        step(1);
        pulse_tx();
        w0 = wr_count;
        step(TO - 3);
        total++;
        if (wr_count !== w0) $display("FAIL early_retry: got %0d expected %0d", wr_count, w0);
        else passed++;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            step(1);
            if (wr_ps2) seen = 1'b1;
        end
        total++;
        if (!seen || init_done !== 1'b0)
            $display("FAIL timeout_retry: got wr=%b init=%b expected wr=1 init=0", seen, init_done);
        else passed++;
        step(1);
        pulse_tx();
        step(1);
        send_byte(8'hFA);
        step(1);
    endtask

    task automatic test_packets();
        logic [7:0] pk [0:1][0:2];
        logic [7:0] h, bx, by;
        logic [20:0] e;
        pk[0][0] = 8'h09; pk[0][1] = 8'h05; pk[0][2] = 8'hFD;
        pk[1][0] = 8'h38; pk[1][1] = 8'hFB; pk[1][2] = 8'h02;
        for (int n = 0; n < 24; n++) begin
            if (n < 2) begin
                h = pk[n][0]; bx = pk[n][1]; by = pk[n][2];
            end else begin
                h = 8'($urandom) | 8'h08; bx = 8'($urandom); by = 8'($urandom);
            end
            e = model(h, bx, by);
            send_byte(h);
            step($urandom_range(0, 5));
            send_byte(bx);
            step($urandom_range(0, 5));
            send_byte(by);
            total++;
            if (m_done_tick !== 1'b1 || {btnm, xm, ym} !== e)
                $display("FAIL packet%0d: got tick=%b %h expected tick=1 %h", n, m_done_tick, {btnm, xm, ym}, e);
            else passed++;
            step(1);
            total++;
            if (m_done_tick !== 1'b0 || {btnm, xm, ym} !== e)
                $display("FAIL hold%0d: got tick=%b %h expected tick=0 %h", n, m_done_tick, {btnm, xm, ym}, e);
            else passed++;
            step($urandom_range(0, 3));
        end
    endtask

    task automatic test_sync();
        int t0;
        t0 = tick_count;
        send_byte(8'h05);
        step(1);
        send_byte(8'h08);
        send_byte(8'h01);
        send_byte(8'h01);
        total++;
        if ({m_done_tick, btnm, xm, ym} !== {1'b1, 3'd0, 9'd1, 9'd1})
            $display("FAIL sync: got %h expected %h", {m_done_tick, btnm, xm, ym}, {1'b1, 3'd0, 9'd1, 9'd1});
        else passed++;
        step(2);
        total++;
        if (tick_count - t0 !== 1) $display("FAIL sync_count: got %0d expected 1", tick_count - t0);
        else passed++;
    endtask

    task automatic test_timeout();
        int t0;
        logic [20:0] e;
        t0 = tick_count;
        send_byte(8'h08);
        step(1);
        send_byte(8'h10);
        step(TO + 5);
        total++;
        if (tick_count !== t0) $display("FAIL timeout_tick: got %0d expected %0d", tick_count, t0);
        else passed++;
        send_byte(8'h0A);
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if ({m_done_tick, btnm, xm, ym} !== {1'b1, 3'b010, 18'd0})
            $display("FAIL after_timeout: got %h expected %h", {m_done_tick, btnm, xm, ym}, {1'b1, 3'b010, 18'd0});
        else passed++;
        step(2);
        e = model(8'hE9, 8'h33, 8'h44);
        send_byte(8'hE9);
        step(TO - 4);
        send_byte(8'h33);
        step(TO - 4);
        send_byte(8'h44);
        total++;
        if (m_done_tick !== 1'b1 || {btnm, xm, ym} !== e)
            $display("FAIL slow_packet: got tick=%b %h expected tick=1 %h", m_done_tick, {btnm, xm, ym}, e);
        else passed++;
        step(2);
    endtask

    task automatic test_overflow_reset();
        send_byte(8'h58);
        send_byte(8'h00);
        send_byte(8'h00);
        total++;
        if ({m_done_tick, xm, ym} !== {1'b1, 9'h100, 9'h000})
            $display("FAIL overflow: got %h expected %h", {m_done_tick, xm, ym}, {1'b1, 9'h100, 9'h000});
        else passed++;
        step(2);
        send_byte(8'h09);
        send_byte(8'h05);
        reset = 1'b1;
        #1;
        total++;
        if ({wr_ps2, init_done, xm, ym, btnm, m_done_tick} !== 24'd0)
            $display("FAIL mid_reset: got %h expected 0", {wr_ps2, init_done, xm, ym, btnm, m_done_tick});
        else passed++;
        step(2);
        reset = 1'b0;
        step(1);
        total++;
        if (wr_ps2 !== 1'b1 || init_done !== 1'b0)
            $display("FAIL restart_wr: got wr=%b init=%b expected wr=1 init=0", wr_ps2, init_done);
        else passed++;
    endtask

    initial begin
        test_reset();
        test_init_retry();
        test_packets();
        test_sync();
        test_timeout();
        test_overflow_reset();
        bring_up();
        test_packets();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
